// File: rtl/scc_pkg.sv
// Shared SCC pipeline definitions: instruction classes, ALU codes, decoded-field
// bundle and decode-stage state.
package scc_pkg;

   localparam logic [1:0] CLS_DATA_IMM = 2'b00;
   localparam logic [1:0] CLS_DATA_REG = 2'b01;
   localparam logic [1:0] CLS_LDST     = 2'b10;
   localparam logic [1:0] CLS_SYS      = 2'b11;

   localparam logic [2:0] ALU_ADD = 3'd1;
   localparam logic [2:0] ALU_SUB = 3'd2;
   localparam logic [2:0] ALU_AND = 3'd3;
   localparam logic [2:0] ALU_OR  = 3'd4;
   localparam logic [2:0] ALU_XOR = 3'd5;
   localparam logic [2:0] ALU_NOT = 3'd6;

   typedef struct packed {
      logic [1:0]  cls;
      logic        special;
      logic [3:0]  sub;
      logic [2:0]  alu_oc;
      logic [3:0]  cond;
      logic [2:0]  rd;
      logic [2:0]  rs1;
      logic [2:0]  rs2;
      logic [2:0]  ptr;
      logic        rd_we;
      logic        use_rs1;
      logic        use_rs2;
      logic        use_ptr;
      logic        illegal;
      logic        is_halt;
      logic        imm_sext;
      logic [15:0] imm;
   } dec_t;

   typedef enum logic {
      ST_RUN,
      ST_HALTED
   } state_t;

endpackage

// File: rtl/decode_stage_instr_fields.sv
// Combinational field extraction and operand-usage flags for one instruction word.
module instr_fields
   import scc_pkg::*;
#(
   parameter int NUM_REGS = 8,
   parameter bit SEXT_IMM = 1'b1
)(
   input  logic [31:0] instr,
   output dec_t        dec
);

   localparam logic [3:0] NR = 4'(NUM_REGS);

   logic alu_code;

   always_comb begin
      alu_code = instr[29] && (instr[27:25] inside {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR});
      dec          = '0;
      dec.cls      = instr[31:30];
      dec.special  = instr[29];
      dec.sub      = instr[28:25];
      dec.rd       = instr[24:22];
      dec.rs1      = instr[21:19];
      dec.ptr      = instr[21:19];
      dec.rs2      = instr[18:16];
      dec.imm      = instr[15:0];
      dec.imm_sext = SEXT_IMM;
      case (instr[31:30])
         CLS_DATA_IMM: begin
            if (instr[29:26] == 4'b0000) begin
               dec.rd_we    = 1'b1;
               dec.imm_sext = 1'b0;
            end else if (alu_code) begin
               dec.rd_we   = 1'b1;
               dec.use_rs1 = 1'b1;
               dec.alu_oc  = instr[27:25];
            end else if (instr[29:25] inside {5'd2, 5'd3, 5'd4, 5'd5}) begin
               dec.rd_we   = 1'b1;
               dec.use_rs1 = 1'b1;
            end else begin
               dec.illegal = 1'b1;
            end
         end
         CLS_DATA_REG: begin
            if (alu_code) begin
               dec.rd_we   = 1'b1;
               dec.use_rs1 = 1'b1;
               dec.use_rs2 = 1'b1;
               dec.alu_oc  = instr[27:25];
            end else if (instr[29:25] == {2'b10, ALU_NOT}) begin
               dec.rd_we   = 1'b1;
               dec.use_rs1 = 1'b1;
               dec.alu_oc  = ALU_NOT;
            end else begin
               dec.illegal = 1'b1;
            end
         end
         CLS_LDST: begin
            dec.use_ptr = 1'b1;
            if (instr[25]) begin
               dec.use_rs2 = 1'b1;
               dec.rs2     = instr[24:22];
            end else begin
               dec.rd_we = 1'b1;
            end
         end
         default: begin
            case (instr[28:25])
               4'b0000: ;
               4'b0001: dec.cond = instr[24:21];
               4'b0010: dec.use_ptr = 1'b1;
               default: begin
                  if (instr[27])      ;
                  else if (instr[28]) dec.is_halt = 1'b1;
                  else                dec.illegal = 1'b1;
               end
            endcase
         end
      endcase
      // A destination outside the scoreboard cannot be tracked, so reject it.
      if (dec.rd_we && ({1'b0, dec.rd} >= NR)) dec.illegal = 1'b1;
      if (dec.illegal) begin
         dec.rd_we   = 1'b0;
         dec.use_rs1 = 1'b0;
         dec.use_rs2 = 1'b0;
         dec.use_ptr = 1'b0;
         dec.alu_oc  = '0;
         dec.cond    = '0;
         dec.is_halt = 1'b0;
      end
   end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: one-deep holding register, pending-write scoreboard
// and RUN/HALTED control between fetch and register read.
//
// state     | meaning
// ST_RUN    | accepting and issuing instructions
// ST_HALTED | HALT issued; no accept, no issue until resume
module decode_stage
   import scc_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 8,
   parameter bit SEXT_IMM = 1'b1
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       in_instr,
   input  logic              flush,
   input  logic              resume,
   input  logic              wb_valid,
   input  logic [2:0]        wb_addr,
   output logic              iss_valid,
   input  logic              iss_ready,
   output logic [1:0]        iss_class,
   output logic              iss_special,
   output logic [3:0]        iss_sub,
   output logic [2:0]        iss_alu_oc,
   output logic [3:0]        iss_cond,
   output logic [2:0]        iss_rd,
   output logic [2:0]        iss_rs1,
   output logic [2:0]        iss_rs2,
   output logic [2:0]        iss_ptr,
   output logic              iss_rd_we,
   output logic              iss_use_rs1,
   output logic              iss_use_rs2,
   output logic              iss_use_ptr,
   output logic [DATA_W-1:0] iss_imm,
   output logic              iss_illegal,
   output logic              halted,
   output logic              stall_hazard
);

   dec_t                dec;
   dec_t                held;
   logic                held_valid;
   state_t              state;
   logic [NUM_REGS-1:0] pend;
   logic [7:0]          pend_x;
   logic [7:0]          set_mask;
   logic [7:0]          clr_mask;
   logic                run;
   logic                hazard;
   logic                issue;
   logic                accept;

   instr_fields #(.NUM_REGS(NUM_REGS), .SEXT_IMM(SEXT_IMM)) u_fields (
      .instr (in_instr),
      .dec   (dec)
   );

   assign run    = (state == ST_RUN);
   assign pend_x = 8'(pend);
   assign hazard = (held.use_rs1 & pend_x[held.rs1]) | (held.use_rs2 & pend_x[held.rs2]) |
                   (held.use_ptr & pend_x[held.ptr]) | (held.rd_we & pend_x[held.rd]);

   // Flush also masks iss_valid so downstream never takes an instruction being dropped.
   assign iss_valid    = held_valid & run & ~hazard & ~flush;
   assign issue        = iss_valid & iss_ready;
   assign in_ready     = run & ~flush & (~held_valid | issue);
   assign accept       = in_valid & in_ready;
   assign stall_hazard = held_valid & hazard;
   assign halted       = (state == ST_HALTED);

   assign set_mask = (issue && held.rd_we) ? (8'd1 << held.rd) : 8'd0;
   assign clr_mask = wb_valid ? (8'd1 << wb_addr) : 8'd0;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         held_valid <= 1'b0;
         held       <= '0;
         pend       <= '0;
         state      <= ST_RUN;
      end else begin
         pend <= (pend & ~clr_mask[NUM_REGS-1:0]) | set_mask[NUM_REGS-1:0];
         if (flush) begin
            held_valid <= 1'b0;
         end else if (accept) begin
            held_valid <= 1'b1;
            held       <= dec;
         end else if (issue) begin
            held_valid <= 1'b0;
         end
         case (state)
            ST_RUN:    if (issue && held.is_halt) state <= ST_HALTED;
            ST_HALTED: if (resume) state <= ST_RUN;
            default:   state <= ST_RUN;
         endcase
      end
   end

   assign iss_class   = held.cls;
   assign iss_special = held.special;
   assign iss_sub     = held.sub;
   assign iss_alu_oc  = held.alu_oc;
   assign iss_cond    = held.cond;
   assign iss_rd      = held.rd;
   assign iss_rs1     = held.rs1;
   assign iss_rs2     = held.rs2;
   assign iss_ptr     = held.ptr;
   assign iss_rd_we   = held.rd_we;
   assign iss_use_rs1 = held.use_rs1;
   assign iss_use_rs2 = held.use_rs2;
   assign iss_use_ptr = held.use_ptr;
   assign iss_illegal = held.illegal;
   assign iss_imm     = held.imm_sext ? DATA_W'($signed(held.imm)) : DATA_W'(held.imm);

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus a randomized run
// against a transaction-level model of decode, scoreboard and halt behaviour.
module tb_decode_stage;

   localparam int K_MOV = 0, K_ALUI = 1, K_MISC = 2, K_ALUR = 3, K_NOT = 4, K_LD = 5,
                  K_ST = 6, K_B = 7, K_BC = 8, K_BR = 9, K_NOP = 10, K_HALT = 11, K_ILL = 12;

   typedef struct packed {
      logic [1:0]  cls;
      logic        special;
      logic [3:0]  sub;
      logic [2:0]  alu_oc;
      logic [3:0]  cond;
      logic [2:0]  rd, rs1, rs2, ptr;
      logic        rd_we, u1, u2, up, illegal;
      logic [31:0] imm;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n, in_valid, flush, resume, wb_valid, iss_ready;
   logic [31:0] in_instr;
   logic [2:0]  wb_addr;
   logic        in_ready, iss_valid, iss_special, iss_rd_we, iss_use_rs1, iss_use_rs2, iss_use_ptr;
   logic        iss_illegal, halted, stall_hazard;
   logic [1:0]  iss_class;
   logic [3:0]  iss_sub, iss_cond;
   logic [2:0]  iss_alu_oc, iss_rd, iss_rs1, iss_rs2, iss_ptr;
   logic [31:0] iss_imm;

   int n_checks = 0;
   int n_err    = 0;

   bit          m_pend [8];
   bit          m_held, m_halted;
   logic [31:0] m_instr;

   always #5 clk = ~clk;

   decode_stage #(.DATA_W(32), .NUM_REGS(8), .SEXT_IMM(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
      .flush(flush), .resume(resume), .wb_valid(wb_valid), .wb_addr(wb_addr),
      .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_class(iss_class),
      .iss_special(iss_special), .iss_sub(iss_sub), .iss_alu_oc(iss_alu_oc), .iss_cond(iss_cond),
      .iss_rd(iss_rd), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_ptr(iss_ptr),
      .iss_rd_we(iss_rd_we), .iss_use_rs1(iss_use_rs1), .iss_use_rs2(iss_use_rs2),
      .iss_use_ptr(iss_use_ptr), .iss_imm(iss_imm), .iss_illegal(iss_illegal),
      .halted(halted), .stall_hazard(stall_hazard)
   );

   function automatic int kind_of(logic [31:0] w);
      bit alu;
      alu = w[29] && (w[27:25] >= 3'd1) && (w[27:25] <= 3'd5);
      case (w[31:30])
         2'b00: begin
            if (w[29:25] == 5'd0 || w[29:25] == 5'd1) return K_MOV;
            if (alu) return K_ALUI;
            if (w[29:25] >= 5'd2 && w[29:25] <= 5'd5) return K_MISC;
            return K_ILL;
         end
         2'b01: begin
            if (alu) return K_ALUR;
            if (w[29:25] == 5'b10110) return K_NOT;
            return K_ILL;
         end
         2'b10: return w[25] ? K_ST : K_LD;
         default: begin
            if (w[28:25] == 4'd0) return K_B;
            if (w[28:25] == 4'd1) return K_BC;
            if (w[28:25] == 4'd2) return K_BR;
            if (w[27]) return K_NOP;
            if (w[28]) return K_HALT;
            return K_ILL;
         end
      endcase
   endfunction

   function automatic exp_t ref_decode(logic [31:0] w);
      exp_t e;
      int   k;
      k = kind_of(w);
      e = '0;
      e.cls = w[31:30]; e.special = w[29]; e.sub = w[28:25];
      e.rd = w[24:22]; e.rs1 = w[21:19]; e.ptr = w[21:19]; e.rs2 = w[18:16];
      e.imm = (k == K_MOV) ? {16'h0000, w[15:0]} : {{16{w[15]}}, w[15:0]};
      e.illegal = (k == K_ILL);
      case (k)
         K_MOV:  e.rd_we = 1'b1;
         K_ALUI: begin e.rd_we = 1'b1; e.u1 = 1'b1; e.alu_oc = w[27:25]; end
         K_MISC: begin e.rd_we = 1'b1; e.u1 = 1'b1; end
         K_ALUR: begin e.rd_we = 1'b1; e.u1 = 1'b1; e.u2 = 1'b1; e.alu_oc = w[27:25]; end
         K_NOT:  begin e.rd_we = 1'b1; e.u1 = 1'b1; e.alu_oc = w[27:25]; end
         K_LD:   begin e.rd_we = 1'b1; e.up = 1'b1; end
         K_ST:   begin e.u2 = 1'b1; e.up = 1'b1; e.rs2 = w[24:22]; end
         K_BC:   e.cond = w[24:21];
         K_BR:   e.up = 1'b1;
         default: ;
      endcase
      return e;
   endfunction

   function automatic bit model_hazard(exp_t e);
      return (e.u1 && m_pend[e.rs1]) || (e.u2 && m_pend[e.rs2]) ||
             (e.up && m_pend[e.ptr]) || (e.rd_we && m_pend[e.rd]);
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [31:0] w;
      w = $urandom;
      case ($urandom_range(0, 9))
         0: w[31:26] = 6'b000000;
         1: begin w[31:29] = 3'b001; w[27:25] = 3'($urandom_range(1, 5)); end
         2: begin w[31:29] = 3'b011; w[27:25] = 3'($urandom_range(1, 5)); end
         3: w[31:25] = 7'b0110110;
         4: w[31:30] = 2'b10;
         5: begin w[31:30] = 2'b11; w[28:25] = 4'($urandom_range(0, 2)); end
         6: begin w[31:30] = 2'b11; w[27] = 1'b1; end
         7: begin w[31:30] = 2'b11; w[28:27] = ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b01; end
         8: w[31:25] = {2'b00, 5'($urandom_range(2, 5))};
         default: ;
      endcase
      return w;
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; flush = 1'b0; resume = 1'b0;
      wb_valid = 1'b0; wb_addr = '0; iss_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset(); #1;
      n_checks++; if (iss_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++;
         $display("FAIL reset_hs: valid=%b ready=%b exp 0/1", iss_valid, in_ready); end
      n_checks++; if (halted !== 1'b0 || stall_hazard !== 1'b0) begin n_err++;
         $display("FAIL reset_status: halted=%b stall=%b exp 0/0", halted, stall_hazard); end
      n_checks++; if ({iss_class, iss_sub, iss_rd, iss_rs1, iss_rs2, iss_imm, iss_illegal, iss_rd_we} !== '0) begin
         n_err++; $display("FAIL reset_fields: rd=%0d imm=%h ill=%b exp 0", iss_rd, iss_imm, iss_illegal); end
      in_valid = 1'b1; in_instr = 32'h22500005; iss_ready = 1'b1;
      @(negedge clk); in_instr = 32'h62C90000;
      @(negedge clk); in_valid = 1'b0; #1;
      n_checks++; if (stall_hazard !== 1'b1) begin n_err++;
         $display("FAIL reset_setup_stall: got %b exp 1", stall_hazard); end
      rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1; #1;
      n_checks++; if (stall_hazard !== 1'b0 || iss_valid !== 1'b0 || iss_rd !== 3'd0) begin n_err++;
         $display("FAIL reset_mid_stall: stall=%b valid=%b rd=%0d exp 0/0/0", stall_hazard, iss_valid, iss_rd); end
      in_valid = 1'b1; in_instr = 32'h62C90000;
      @(negedge clk); in_valid = 1'b0; #1;
      n_checks++; if (iss_valid !== 1'b1) begin n_err++;
         $display("FAIL reset_pend_cleared: valid=%b exp 1", iss_valid); end
   endtask

   task automatic test_add_imm();
      do_reset();
      in_valid = 1'b1; in_instr = 32'h22500005; iss_ready = 1'b1; #1;
      n_checks++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL add_in_ready: got %b exp 1", in_ready); end
      @(negedge clk); in_valid = 1'b0; #1;
      n_checks++; if (iss_valid !== 1'b1) begin n_err++; $display("FAIL add_valid: got %b exp 1", iss_valid); end
      n_checks++; if (iss_rd !== 3'd1 || iss_rs1 !== 3'd2) begin n_err++;
         $display("FAIL add_regs: rd=%0d rs1=%0d exp 1/2", iss_rd, iss_rs1); end
      n_checks++; if ({iss_rd_we, iss_use_rs1, iss_use_rs2, iss_use_ptr} !== 4'b1100) begin n_err++;
         $display("FAIL add_flags: got %b exp 1100", {iss_rd_we, iss_use_rs1, iss_use_rs2, iss_use_ptr}); end
      n_checks++; if (iss_imm !== 32'h00000005 || iss_alu_oc !== 3'b001) begin n_err++;
         $display("FAIL add_imm_oc: imm=%h oc=%b exp 00000005/001", iss_imm, iss_alu_oc); end
      @(negedge clk); #1;
      n_checks++; if (iss_valid !== 1'b0) begin n_err++; $display("FAIL add_drained: got %b exp 0", iss_valid); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] seq [3];
      seq = '{32'h22400000, 32'h22800000, 32'h22C00000};
      do_reset();
      iss_ready = 1'b1; in_valid = 1'b1; in_instr = seq[0];
      @(negedge clk);
      for (int i = 1; i <= 3; i++) begin
         if (i < 3) in_instr = seq[i]; else in_valid = 1'b0;
         #1;
         n_checks++; if (iss_valid !== 1'b1 || iss_rd !== 3'(i)) begin n_err++;
            $display("FAIL b2b_%0d: valid=%b rd=%0d exp 1/%0d", i, iss_valid, iss_rd, i); end
         n_checks++; if (in_ready !== 1'b1) begin n_err++;
            $display("FAIL b2b_ready_%0d: got %b exp 1", i, in_ready); end
         @(negedge clk);
      end
   endtask

   task automatic test_raw_hazard();
      do_reset();
      iss_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h22500005;
      @(negedge clk); in_instr = 32'h62C90000;
      @(negedge clk); in_valid = 1'b0; #1;
      n_checks++; if (iss_valid !== 1'b0 || stall_hazard !== 1'b1) begin n_err++;
         $display("FAIL raw_stall: valid=%b stall=%b exp 0/1", iss_valid, stall_hazard); end
      for (int i = 0; i < 2; i++) begin
         @(negedge clk); #1;
         n_checks++; if (stall_hazard !== 1'b1 || iss_rd !== 3'd3) begin n_err++;
            $display("FAIL raw_hold_%0d: stall=%b rd=%0d exp 1/3", i, stall_hazard, iss_rd); end
      end
      wb_valid = 1'b1; wb_addr = 3'd1; #1;
      n_checks++; if (iss_valid !== 1'b0) begin n_err++;
         $display("FAIL raw_wb_same_cycle: valid=%b exp 0", iss_valid); end
      @(negedge clk); wb_valid = 1'b0; #1;
      n_checks++; if (iss_valid !== 1'b1 || stall_hazard !== 1'b0) begin n_err++;
         $display("FAIL raw_release: valid=%b stall=%b exp 1/0", iss_valid, stall_hazard); end
      n_checks++; if ({iss_rd, iss_rs1, iss_rs2, iss_use_rs2} !== {3'd3, 3'd1, 3'd1, 1'b1}) begin n_err++;
         $display("FAIL raw_fields: rd=%0d rs1=%0d rs2=%0d u2=%b exp 3/1/1/1", iss_rd, iss_rs1, iss_rs2, iss_use_rs2); end
      wb_valid = 1'b1; wb_addr = 3'd3; in_valid = 1'b1; in_instr = 32'h22180000;
      @(negedge clk); wb_valid = 1'b0; in_valid = 1'b0; #1;
      n_checks++; if (iss_valid !== 1'b0 || stall_hazard !== 1'b1) begin n_err++;
         $display("FAIL set_wins: valid=%b stall=%b exp 0/1", iss_valid, stall_hazard); end
      wb_valid = 1'b1; wb_addr = 3'd3;
      @(negedge clk); wb_valid = 1'b0; #1;
      n_checks++; if (iss_valid !== 1'b1) begin n_err++;
         $display("FAIL set_wins_release: valid=%b exp 1", iss_valid); end
   endtask

   task automatic test_imm_ext();
      do_reset();
      in_valid = 1'b1; in_instr = 32'h8128FFFC; iss_ready = 1'b0;
      @(negedge clk); in_valid = 1'b0; #1;
      n_checks++; if (iss_valid !== 1'b1 || iss_rd !== 3'd4 || iss_ptr !== 3'd5) begin n_err++;
         $display("FAIL load_regs: valid=%b rd=%0d ptr=%0d exp 1/4/5", iss_valid, iss_rd, iss_ptr); end
      n_checks++; if (iss_imm !== 32'hFFFFFFFC || {iss_rd_we, iss_use_ptr, iss_use_rs1} !== 3'b110) begin n_err++;
         $display("FAIL load_imm: imm=%h flags=%b exp FFFFFFFC/110", iss_imm, {iss_rd_we, iss_use_ptr, iss_use_rs1}); end
      @(negedge clk); #1;
      n_checks++; if (iss_imm !== 32'hFFFFFFFC || iss_rd !== 3'd4) begin n_err++;
         $display("FAIL load_stable: imm=%h rd=%0d exp FFFFFFFC/4", iss_imm, iss_rd); end
      iss_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h00008000;
      @(negedge clk); in_instr = 32'h82B00010; #1;
      n_checks++; if (iss_valid !== 1'b1 || iss_imm !== 32'h00008000 || iss_rd_we !== 1'b1 || iss_use_ptr !== 1'b0) begin
         n_err++; $display("FAIL mov_zext: valid=%b imm=%h we=%b up=%b exp 1/00008000/1/0", iss_valid, iss_imm, iss_rd_we, iss_use_ptr); end
      @(negedge clk); in_valid = 1'b0; #1;
      n_checks++; if ({iss_rd_we, iss_use_rs2, iss_use_ptr, iss_rs2, iss_ptr} !== {3'b011, 3'd2, 3'd6} || iss_imm !== 32'h10) begin
         n_err++; $display("FAIL store: flags=%b rs2=%0d ptr=%0d imm=%h exp 011/2/6/00000010", {iss_rd_we, iss_use_rs2, iss_use_ptr}, iss_rs2, iss_ptr, iss_imm); end
   endtask

   task automatic test_halt_nop();
      do_reset();
      iss_ready = 1'b1; in_valid = 1'b1; in_instr = 32'hD0000000;
      @(negedge clk); in_valid = 1'b0; #1;
      n_checks++; if (iss_valid !== 1'b1 || halted !== 1'b0) begin n_err++;
         $display("FAIL halt_held: valid=%b halted=%b exp 1/0", iss_valid, halted); end
      @(negedge clk); in_valid = 1'b1; in_instr = 32'hC8000000; #1;
      n_checks++; if (halted !== 1'b1 || in_ready !== 1'b0 || iss_valid !== 1'b0) begin n_err++;
         $display("FAIL halt_enter: halted=%b ready=%b valid=%b exp 1/0/0", halted, in_ready, iss_valid); end
      repeat (2) @(negedge clk);
      #1;
      n_checks++; if (in_ready !== 1'b0 || halted !== 1'b1) begin n_err++;
         $display("FAIL halt_stay: ready=%b halted=%b exp 0/1", in_ready, halted); end
      resume = 1'b1; #1;
      n_checks++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL resume_cycle: ready=%b exp 0", in_ready); end
      @(negedge clk); resume = 1'b0; #1;
      n_checks++; if (halted !== 1'b0 || in_ready !== 1'b1) begin n_err++;
         $display("FAIL resume_run: halted=%b ready=%b exp 0/1", halted, in_ready); end
      @(negedge clk); in_valid = 1'b0; #1;
      n_checks++; if (iss_valid !== 1'b1 || iss_class !== 2'b11) begin n_err++;
         $display("FAIL nop_valid: valid=%b cls=%b exp 1/11", iss_valid, iss_class); end
      n_checks++; if ({iss_rd_we, iss_use_rs1, iss_use_rs2, iss_use_ptr, iss_illegal} !== 5'b0) begin n_err++;
         $display("FAIL nop_flags: got %b exp 00000", {iss_rd_we, iss_use_rs1, iss_use_rs2, iss_use_ptr, iss_illegal}); end
   endtask

   task automatic test_illegal();
      do_reset();
      iss_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h40000000;
      @(negedge clk); in_instr = 32'h22400000; #1;
      n_checks++; if (iss_valid !== 1'b1 || iss_illegal !== 1'b1) begin n_err++;
         $display("FAIL illegal_flag: valid=%b ill=%b exp 1/1", iss_valid, iss_illegal); end
      n_checks++; if ({iss_rd_we, iss_use_rs1, iss_use_rs2, iss_use_ptr} !== 4'b0) begin n_err++;
         $display("FAIL illegal_usage: got %b exp 0000", {iss_rd_we, iss_use_rs1, iss_use_rs2, iss_use_ptr}); end
      @(negedge clk); in_valid = 1'b0; #1;
      n_checks++; if (iss_valid !== 1'b1 || stall_hazard !== 1'b0 || iss_illegal !== 1'b0) begin n_err++;
         $display("FAIL illegal_no_pend: valid=%b stall=%b ill=%b exp 1/0/0", iss_valid, stall_hazard, iss_illegal); end
   endtask

   task automatic test_flush();
      do_reset();
      iss_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h22500005;
      @(negedge clk); in_instr = 32'h62C90000;
      @(negedge clk); in_instr = 32'h00008000; flush = 1'b1; #1;
      n_checks++; if (in_ready !== 1'b0 || iss_valid !== 1'b0) begin n_err++;
         $display("FAIL flush_cycle: ready=%b valid=%b exp 0/0", in_ready, iss_valid); end
      @(negedge clk); flush = 1'b0; in_valid = 1'b0; #1;
      n_checks++; if (stall_hazard !== 1'b0 || iss_valid !== 1'b0) begin n_err++;
         $display("FAIL flush_dropped: stall=%b valid=%b exp 0/0", stall_hazard, iss_valid); end
      repeat (2) @(negedge clk);
      #1;
      n_checks++; if (iss_valid !== 1'b0) begin n_err++; $display("FAIL flush_never_issues: valid=%b exp 0", iss_valid); end
      in_valid = 1'b1; in_instr = 32'h62C90000;
      @(negedge clk); in_valid = 1'b0; #1;
      n_checks++; if (stall_hazard !== 1'b1) begin n_err++;
         $display("FAIL flush_pend_kept: stall=%b exp 1", stall_hazard); end
      wb_valid = 1'b1; wb_addr = 3'd1;
      @(negedge clk); wb_valid = 1'b0; #1;
      n_checks++; if (iss_valid !== 1'b1 || iss_rd !== 3'd3) begin n_err++;
         $display("FAIL flush_wb_release: valid=%b rd=%0d exp 1/3", iss_valid, iss_rd); end
   endtask

   task automatic test_random();
      exp_t e;
      bit   hz, exp_valid, exp_issue, exp_ready;
      do_reset();
      foreach (m_pend[i]) m_pend[i] = 1'b0;
      m_held = 1'b0; m_halted = 1'b0; m_instr = '0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         in_valid  = ($urandom_range(0, 1) == 1);
         in_instr  = rand_instr();
         iss_ready = ($urandom_range(0, 3) != 0);
         flush     = ($urandom_range(0, 15) == 0);
         resume    = ($urandom_range(0, 3) == 0);
         wb_valid  = ($urandom_range(0, 2) == 0);
         wb_addr   = 3'($urandom_range(0, 7));
         #1;
         e = ref_decode(m_instr);
         hz = m_held && model_hazard(e);
         exp_valid = m_held && !m_halted && !hz && !flush;
         exp_issue = exp_valid && iss_ready;
         exp_ready = !m_halted && !flush && (!m_held || exp_issue);
         n_checks++; if (iss_valid !== exp_valid || in_ready !== exp_ready) begin n_err++;
            $display("FAIL rand_hs cyc %0d: valid=%b ready=%b exp %b/%b", cyc, iss_valid, in_ready, exp_valid, exp_ready); end
         n_checks++; if (stall_hazard !== hz || halted !== m_halted) begin n_err++;
            $display("FAIL rand_status cyc %0d: stall=%b halted=%b exp %b/%b", cyc, stall_hazard, halted, hz, m_halted); end
         if (m_held) begin
            n_checks++;
            if ({iss_class, iss_special, iss_sub, iss_alu_oc, iss_cond, iss_rd, iss_rs1, iss_rs2, iss_ptr,
                 iss_rd_we, iss_use_rs1, iss_use_rs2, iss_use_ptr, iss_illegal, iss_imm} !== e) begin
               n_err++;
               $display("FAIL rand_fields cyc %0d instr %h: got %h exp %h", cyc, m_instr,
                        {iss_class, iss_special, iss_sub, iss_alu_oc, iss_cond, iss_rd, iss_rs1, iss_rs2, iss_ptr,
                         iss_rd_we, iss_use_rs1, iss_use_rs2, iss_use_ptr, iss_illegal, iss_imm}, e);
            end
         end
         if (wb_valid) m_pend[wb_addr] = 1'b0;
         if (exp_issue && e.rd_we) m_pend[e.rd] = 1'b1;
         if (!m_halted && exp_issue && kind_of(m_instr) == K_HALT) m_halted = 1'b1;
         else if (m_halted && resume) m_halted = 1'b0;
         if (flush) m_held = 1'b0;
         else if (in_valid && exp_ready) begin m_held = 1'b1; m_instr = in_instr; end
         else if (exp_issue) m_held = 1'b0;
         @(negedge clk);
      end
   endtask

   initial begin
      test_reset();
      test_add_imm();
      test_back_to_back();
      test_raw_hazard();
      test_imm_ext();
      test_halt_nop();
      test_illegal();
      test_flush();
      test_random();
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
